// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between instruction fetch and load/store.
//   At most one access is granted per cycle; data has priority over fetch.
//   Read data arrives one cycle after the address. It is steered back to the
//   requester that issued the read, as recorded in the owner register.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   When defined, a saturating counter tracks consecutive data grants while
//   fetch is waiting. Fetch is then forced through once STARVE_MAX is reached.
//   When undefined, data has strict priority.
//
// Ports
//   clk, rst (synchronous, active-low), flush (cancels in-flight fetch)
//   if_req/if_addr -> if_gnt (comb), if_valid/if_data (response phase)
//   d_req/d_addr/d_wmode/d_wdata -> d_gnt (comb), d_valid/d_rdata
//   ram_addr/ram_write_mode/ram_write_data -> RAM, ram_data <- RAM (1-cycle)
module ram_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_valid,
    output logic [XLEN-1:0] if_data,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [1:0]      d_wmode,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] ram_addr,
    output logic [1:0]      ram_write_mode,
    output logic [XLEN-1:0] ram_write_data,
    input  logic [XLEN-1:0] ram_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DRD  = 2'd2,
        OWN_DWR  = 2'd3
    } owner_t;

    owner_t owner_r;
    owner_t owner_next_s;
    logic   force_if_s;
    logic   d_gnt_s;
    logic   if_gnt_s;

    // A guard of zero would force fetch forever and lock data out
    if (STARVE_MAX < 1) begin : g_starve_max_check
        $error("ram_arbiter: STARVE_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_r;

    // Saturating count of data grants taken while fetch was waiting
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!if_req || if_gnt_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (d_gnt_s && (starve_cnt_r != STARVE_MAX_C)) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Fetch wins one cycle once data has been granted STARVE_MAX times in a row
    always_comb begin
        force_if_s = 1'b0;
        if ((starve_cnt_r == STARVE_MAX_C) && if_req && !flush) begin
            force_if_s = 1'b1;
        end else begin
            force_if_s = 1'b0;
        end
    end
`else
    // Strict data priority: fetch is never forced
    always_comb begin
        force_if_s = 1'b0;
    end
`endif

    // Grant decision; flush blocks a fresh fetch but never a data access
    always_comb begin
        d_gnt_s  = rst & d_req & ~force_if_s;
        if_gnt_s = rst & ~d_gnt_s & if_req & ~flush;
    end

    assign d_gnt  = d_gnt_s;
    assign if_gnt = if_gnt_s;

    // RAM port mux; fetch is always a read, idle drives zeros
    always_comb begin
        ram_addr       = {XLEN{1'b0}};
        ram_write_mode = 2'b00;
        ram_write_data = {XLEN{1'b0}};
        if (d_gnt_s) begin
            ram_addr       = d_addr;
            ram_write_mode = d_wmode;
            ram_write_data = d_wdata;
        end else if (if_gnt_s) begin
            ram_addr       = if_addr;
            ram_write_mode = 2'b00;
            ram_write_data = {XLEN{1'b0}};
        end else begin
            ram_addr       = {XLEN{1'b0}};
            ram_write_mode = 2'b00;
            ram_write_data = {XLEN{1'b0}};
        end
    end

    // Next owner follows this cycle's grant
    always_comb begin
        owner_next_s = OWN_NONE;
        if (d_gnt_s) begin
            owner_next_s = (d_wmode == 2'b00) ? OWN_DRD : OWN_DWR;
        end else if (if_gnt_s) begin
            owner_next_s = OWN_IF;
        end else begin
            owner_next_s = OWN_NONE;
        end
    end

    // Owner register; reset drops any pending response
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    // Response steering; flush suppresses the fetch response in the same cycle
    always_comb begin
        if_valid = 1'b0;
        d_valid  = 1'b0;
        if_data  = {XLEN{1'b0}};
        d_rdata  = {XLEN{1'b0}};
        case (owner_r)
            OWN_IF: begin
                if_valid = ~flush;
                if_data  = ram_data;
            end
            OWN_DRD: begin
                d_valid = 1'b1;
                d_rdata = ram_data;
            end
            OWN_DWR: begin
                d_valid = 1'b1;
            end
            default: begin
                if_valid = 1'b0;
                d_valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_data;
    logic        d_req;
    logic [31:0] d_addr;
    logic [1:0]  d_wmode;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [31:0] ram_addr;
    logic [1:0]  ram_write_mode;
    logic [31:0] ram_write_data;
    logic [31:0] ram_data;

    int n_tests;
    int n_fail;

    ram_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_data(if_data),
        .d_req(d_req), .d_addr(d_addr), .d_wmode(d_wmode), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_write_mode(ram_write_mode),
        .ram_write_data(ram_write_data), .ram_data(ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change just after the rising edge, outputs are sampled at the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; d_req = 1'b0; flush = 1'b0;
        d_wmode = 2'b00; d_wdata = 32'h0; ram_data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; ram_data = 32'hFFFF_FFFF;
        d_addr = 32'h0000_0300; if_addr = 32'h0000_0400; d_wdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            n_tests++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt cyc%0d: got %b expected 0", i, if_gnt); end
            n_tests++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt cyc%0d: got %b expected 0", i, d_gnt); end
            n_tests++; if ({if_valid, d_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids cyc%0d: got %b expected 00", i, {if_valid, d_valid}); end
            n_tests++; if ({if_data, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_data cyc%0d: got %h expected 0", i, {if_data, d_rdata}); end
            n_tests++; if ({ram_addr, ram_write_mode, ram_write_data} !== 66'h0) begin n_fail++; $display("FAIL reset_ram cyc%0d: got %h expected 0", i, {ram_addr, ram_write_mode, ram_write_data}); end
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({d_gnt, if_gnt} !== 2'b10) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 10", {d_gnt, if_gnt}); end
        n_tests++; if (ram_addr !== 32'h0000_0300) begin n_fail++; $display("FAIL reset_first_addr: got %h expected 00000300", ram_addr); end
        next_cycle();
        idle(); ram_data = 32'hA5A5_0001;
        @(negedge clk);
        n_tests++; if (d_valid !== 1'b1 || d_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL reset_first_resp: got %b/%h expected 1/a5a50001", d_valid, d_rdata); end
        next_cycle();
        idle();
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        @(negedge clk);
        n_tests++; if ({if_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got %b expected 10", {if_gnt, d_gnt}); end
        n_tests++; if (ram_addr !== 32'h0000_0100 || ram_write_mode !== 2'b00 || ram_write_data !== 32'h0) begin n_fail++; $display("FAIL fetch_ram: got %h/%b/%h expected 00000100/00/0", ram_addr, ram_write_mode, ram_write_data); end
        next_cycle();
        if_req = 1'b0; ram_data = 32'h0000_0013;
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b1 || if_data !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_resp: got %b/%h expected 1/00000013", if_valid, if_data); end
        n_tests++; if (d_valid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_no_dresp: got %b/%h expected 0/0", d_valid, d_rdata); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b0 || if_data !== 32'h0) begin n_fail++; $display("FAIL fetch_idle: got %b/%h expected 0/0", if_valid, if_data); end
        next_cycle();
        idle();
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        d_req = 1'b1; d_wmode = 2'b00; d_addr = 32'h0000_2000;
        @(negedge clk);
        n_tests++; if ({d_gnt, if_gnt} !== 2'b10) begin n_fail++; $display("FAIL cont_gnt: got %b expected 10", {d_gnt, if_gnt}); end
        n_tests++; if (ram_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL cont_addr: got %h expected 00002000", ram_addr); end
        next_cycle();
        d_req = 1'b0; ram_data = 32'hCAFE_0001;
        @(negedge clk);
        n_tests++; if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL cont_dresp: got %b/%h expected 1/cafe0001", d_valid, d_rdata); end
        n_tests++; if (if_data !== 32'h0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL cont_if_quiet: got %b/%h expected 0/0", if_valid, if_data); end
        n_tests++; if (if_gnt !== 1'b1 || ram_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL cont_fetch_next: got %b/%h expected 1/00000104", if_gnt, ram_addr); end
        next_cycle();
        if_req = 1'b0; ram_data = 32'h1234_5678;
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b1 || if_data !== 32'h1234_5678 || d_valid !== 1'b0) begin n_fail++; $display("FAIL cont_fresp: got %b/%h/%b expected 1/12345678/0", if_valid, if_data, d_valid); end
        next_cycle();
        idle();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_wmode = 2'b11; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if (d_gnt !== 1'b1 || ram_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL store_gnt: got %b/%h expected 1/00000040", d_gnt, ram_addr); end
        n_tests++; if (ram_write_mode !== 2'b11 || ram_write_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_ram: got %b/%h expected 11/deadbeef", ram_write_mode, ram_write_data); end
        next_cycle();
        d_wmode = 2'b01; d_addr = 32'h0000_0041; d_wdata = 32'h0000_00AB; ram_data = 32'h5555_AAAA;
        @(negedge clk);
        n_tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL store_resp: got %b/%h expected 1/0", d_valid, d_rdata); end
        n_tests++; if (ram_write_mode !== 2'b01 || ram_write_data !== 32'h0000_00AB) begin n_fail++; $display("FAIL store_byte: got %b/%h expected 01/000000ab", ram_write_mode, ram_write_data); end
        next_cycle();
        idle(); ram_data = 32'h5555_AAAA;
        @(negedge clk);
        n_tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL store_byte_resp: got %b/%h expected 1/0", d_valid, d_rdata); end
        next_cycle();
        idle();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        @(negedge clk);
        n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_pre_gnt: got %b expected 1", if_gnt); end
        next_cycle();
        flush = 1'b1; ram_data = 32'h0BAD_0BAD;
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b0 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL flush_cancel: got %b/%b expected 0/0", if_valid, if_gnt); end
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (if_gnt !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_regrant: got %b/%b expected 1/0", if_gnt, if_valid); end
        next_cycle();
        if_req = 1'b0; ram_data = 32'h0000_0093;
        @(negedge clk);
        n_tests++; if (if_valid !== 1'b1 || if_data !== 32'h0000_0093) begin n_fail++; $display("FAIL flush_refetch: got %b/%h expected 1/00000093", if_valid, if_data); end
        next_cycle();
        flush = 1'b1; if_req = 1'b1; d_req = 1'b1; d_wmode = 2'b00; d_addr = 32'h0000_3000;
        @(negedge clk);
        n_tests++; if ({d_gnt, if_gnt} !== 2'b10) begin n_fail++; $display("FAIL flush_data_gnt: got %b expected 10", {d_gnt, if_gnt}); end
        next_cycle();
        d_req = 1'b0; ram_data = 32'h7777_0003;
        @(negedge clk);
        n_tests++; if (d_valid !== 1'b1 || d_rdata !== 32'h7777_0003 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL flush_data_resp: got %b/%h/%b expected 1/77770003/0", d_valid, d_rdata, if_gnt); end
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h0000_0500;
        @(negedge clk);
        n_tests++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b expected 1", if_gnt); end
        next_cycle();
        rst = 1'b0; d_req = 1'b1;
        @(negedge clk);
        n_tests++; if ({if_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL rmid_no_gnt: got %b expected 00", {if_gnt, d_gnt}); end
        next_cycle();
        rst = 1'b1; idle(); ram_data = 32'h0000_0013;
        @(negedge clk);
        n_tests++; if ({if_valid, d_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_dropped: got %b expected 00", {if_valid, d_valid}); end
        next_cycle();
        idle();
    endtask

    task automatic test_back_to_back();
        logic exp_if;
        for (int i = 0; i < 10; i++) begin
            if_req = 1'b1; d_req = 1'b1; d_wmode = 2'b00;
            d_addr = 32'h0000_1000 + 32'(i); if_addr = 32'h0000_0800;
`ifdef ARB_STARVE_GUARD_EN
            exp_if = ((i % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            @(negedge clk);
            n_tests++; if ({if_gnt, d_gnt} !== {exp_if, ~exp_if}) begin n_fail++; $display("FAIL starve_pattern cyc%0d: got %b expected %b", i, {if_gnt, d_gnt}, {exp_if, ~exp_if}); end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        if_addr = 32'h0;
        d_addr  = 32'h0;
        idle();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_store();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
